// File: rtl/invaders_pkg.sv
// Shared game types and sprite geometry for the invaders playfield.
package invaders_pkg;

    localparam int INV_W_DEFAULT = 32;
    localparam int INV_H_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        HIT      = 2'd2,
        COOLDOWN = 2'd3
    } bullet_state_t;

    // One-axis interval test; callers widen to 11 bits so the sums cannot wrap.
    function automatic logic span_overlap(input logic [10:0] a, input logic [10:0] a_len,
                                          input logic [10:0] b, input logic [10:0] b_len);
        return (a < b + b_len) && (a + a_len > b);
    endfunction

endpackage

// File: rtl/vga_pkg.sv
// Screen geometry for the 1024x768 @ 65 MHz video timing shared by all sprite logic.
package vga_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int V_ACTIVE = 768;
    localparam int COORD_W  = 10;

endpackage

// File: rtl/tick_gen.sv
// Free-running movement tick: one-clock pulse every CLOCKS_PER_TICK cycles.
module tick_gen #(
    parameter int CLOCKS_PER_TICK = 541_666
) (
    input  logic clk65MHz,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (CLOCKS_PER_TICK > 1) ? $clog2(CLOCKS_PER_TICK) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLOCKS_PER_TICK - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/player_bullet.sv
// Player shot: launches from the gun on a fire edge, climbs one step per tick,
// and reports a single-clock hit when it overlaps a live invader.
module player_bullet
    import invaders_pkg::*;
#(
    parameter int CLOCKS_PER_TICK = 541_666,
    parameter int Y_STEP          = 4,
    parameter int BULLET_W        = 2,
    parameter int BULLET_H        = 8,
    parameter int INV_W           = INV_W_DEFAULT,
    parameter int INV_H           = INV_H_DEFAULT,
    parameter int COOLDOWN_TICKS  = 8
) (
    input  logic                         clk65MHz,
    input  logic                         rst_n,
    input  logic                         fire,
    input  logic [vga_pkg::COORD_W-1:0]  player_x,
    input  logic [vga_pkg::COORD_W-1:0]  player_y,
    input  logic [vga_pkg::COORD_W-1:0]  inv_xpos,
    input  logic [vga_pkg::COORD_W-1:0]  inv_ypos,
    input  logic                         inv_alive,
    output logic [vga_pkg::COORD_W-1:0]  bullet_x,
    output logic [vga_pkg::COORD_W-1:0]  bullet_y,
    output logic                         bullet_active,
    output logic                         hit
);

    localparam int CW   = vga_pkg::COORD_W;
    localparam int CD_W = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS) : 1;
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_TICKS - 1);

    bullet_state_t state, state_nxt;

    logic            tick;
    logic            fire_d, fire_re, fire_re_q;
    logic            overlap, top_exit;
    logic            launch, step, kill, hit_nxt, cd_clr, cd_inc;
    logic [CD_W-1:0] cd_cnt;

    tick_gen #(
        .CLOCKS_PER_TICK(CLOCKS_PER_TICK)
    ) u_tick_gen (
        .clk65MHz(clk65MHz),
        .rst_n   (rst_n),
        .tick    (tick)
    );

    // Edge detect is registered so the FSM sees a clean one-clock launch request.
    assign fire_re = fire & ~fire_d;

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            fire_d    <= 1'b0;
            fire_re_q <= 1'b0;
        end else begin
            fire_d    <= fire;
            fire_re_q <= fire_re;
        end
    end

    assign overlap = span_overlap({1'b0, bullet_x}, 11'(BULLET_W), {1'b0, inv_xpos}, 11'(INV_W))
                  && span_overlap({1'b0, bullet_y}, 11'(BULLET_H), {1'b0, inv_ypos}, 11'(INV_H));
    assign top_exit = (bullet_y < CW'(Y_STEP));

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        step      = 1'b0;
        kill      = 1'b0;
        hit_nxt   = 1'b0;
        cd_clr    = 1'b0;
        cd_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (fire_re_q) begin
                    state_nxt = FLY;
                    launch    = 1'b1;
                end
            end
            FLY: begin
                // Collision outranks leaving the top of the screen on the same clock.
                if (overlap && inv_alive) begin
                    state_nxt = HIT;
                    hit_nxt   = 1'b1;
                    kill      = 1'b1;
                end else if (tick && top_exit) begin
                    state_nxt = COOLDOWN;
                    kill      = 1'b1;
                    cd_clr    = 1'b1;
                end else if (tick) begin
                    step = 1'b1;
                end
            end
            HIT: begin
                state_nxt = COOLDOWN;
                cd_clr    = 1'b1;
            end
            COOLDOWN: begin
                if (tick) begin
                    if (cd_cnt == CD_LAST)
                        state_nxt = IDLE;
                    else
                        cd_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n)
            cd_cnt <= '0;
        else if (cd_clr)
            cd_cnt <= '0;
        else if (cd_inc)
            cd_cnt <= cd_cnt + CD_W'(1);
    end

    // Position registers hold their last value through HIT and COOLDOWN.
    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            bullet_x <= '0;
            bullet_y <= '0;
        end else if (launch) begin
            bullet_x <= player_x - CW'(BULLET_W / 2);
            bullet_y <= player_y - CW'(BULLET_H);
        end else if (step) begin
            bullet_y <= bullet_y - CW'(Y_STEP);
        end
    end

    always_ff @(posedge clk65MHz or negedge rst_n) begin
        if (!rst_n) begin
            bullet_active <= 1'b0;
            hit           <= 1'b0;
        end else begin
            hit <= hit_nxt;
            if (launch)
                bullet_active <= 1'b1;
            else if (kill)
                bullet_active <= 1'b0;
        end
    end

endmodule
